// File: rtl/program_loader.sv
// program_loader: streams a framed program image into the core's RAM, then
// releases the core with core_go.
//
// Frame: SYNC_BYTE, L (1..RAMSIZE), L data bytes, checksum (sum of data mod 256).
// After a good frame, the unused RAM tail is zero-filled so stray fetches decode as no-ops.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   in_data/in_valid/in_ready   byte stream, accepted when valid && ready
//   wr_en/wr_addr/wr_data       RAM write port, one byte per cycle (registered)
//   core_go         level, RAM image valid; held until reset
//   load_err        sticky framing/length/checksum error; cleared on the next SYNC_BYTE
//   byte_count      program bytes written in the current frame
module program_loader #(
  parameter int          RAMSIZE   = 64,
  parameter int          ADDRW     = 8,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ADDRW-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             core_go,
  output logic             load_err,
  output logic [7:0]       byte_count
);

  typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_CSUM, S_FILL, S_DONE} state_t;

  state_t           state, state_n;
  logic [7:0]       len_q, len_n;
  logic [7:0]       sum_q, sum_n;
  logic [ADDRW-1:0] fill_q, fill_n;
  logic [7:0]       count_n, data_n;
  logic [ADDRW-1:0] addr_n;
  logic             wr_en_n, go_n, err_n;
  logic             accept;

  // Ready is decoded from the registered state; held low while reset is asserted.
  assign in_ready = reset & ((state == S_SYNC) | (state == S_LEN) |
                             (state == S_DATA) | (state == S_CSUM));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_n = state;
    len_n   = len_q;
    sum_n   = sum_q;
    fill_n  = fill_q;
    count_n = byte_count;
    wr_en_n = 1'b0;
    addr_n  = wr_addr;   // address/data hold when no write
    data_n  = wr_data;
    go_n    = core_go;
    err_n   = load_err;
    case (state)
      S_SYNC: begin
        if (accept && in_data == SYNC_BYTE) begin
          state_n = S_LEN;
          err_n   = 1'b0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (in_data == 8'd0 || 32'(in_data) > RAMSIZE) begin
            err_n   = 1'b1;
            state_n = S_SYNC;
          end else begin
            len_n   = in_data;
            count_n = 8'd0;
            sum_n   = 8'd0;
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          wr_en_n = 1'b1;
          addr_n  = ADDRW'(byte_count);
          data_n  = in_data;
          count_n = byte_count + 8'd1;
          sum_n   = sum_q + in_data;
          if (byte_count + 8'd1 == len_q) state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (in_data == sum_q) begin
            if (32'(len_q) == RAMSIZE) begin
              // Nothing to fill: release the core right away.
              state_n = S_DONE;
              go_n    = 1'b1;
            end else begin
              state_n = S_FILL;
              fill_n  = ADDRW'(len_q);
            end
          end else begin
            err_n   = 1'b1;
            state_n = S_SYNC;
          end
        end
      end
      S_FILL: begin
        wr_en_n = 1'b1;
        addr_n  = fill_q;
        data_n  = 8'd0;
        fill_n  = fill_q + 1'b1;
        if (32'(fill_q) == RAMSIZE - 1) state_n = S_DONE;
      end
      S_DONE: begin
        // Entered on the edge that launches the last fill write, so core_go
        // rises one cycle after that write is presented.
        go_n = 1'b1;
      end
      default: state_n = S_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_SYNC;
      len_q      <= '0;
      sum_q      <= '0;
      fill_q     <= '0;
      byte_count <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      core_go    <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state      <= state_n;
      len_q      <= len_n;
      sum_q      <= sum_n;
      fill_q     <= fill_n;
      byte_count <= count_n;
      wr_en      <= wr_en_n;
      wr_addr    <= addr_n;
      wr_data    <= data_n;
      core_go    <= go_n;
      load_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the driver pushes expected RAM writes
// into a queue, a negedge monitor pops and compares each presented write.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       core_go;
  logic       load_err;
  logic [7:0] byte_count;

  program_loader #(.RAMSIZE(64), .ADDRW(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_go(core_go), .load_err(load_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  int         vecs = 0, errs = 0;
  int         cyc = 0, last_wr_cyc = 0, acc_cyc = 0;
  logic [7:0] pl [64];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, wr_addr}, {24'd0, e.a});
        chk("wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vecs++;
      errs++;
      $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
    chk({tag, "_wr_addr"},    {24'd0, wr_addr},    32'd0);
    chk({tag, "_wr_data"},    {24'd0, wr_data},    32'd0);
    chk({tag, "_core_go"},    {31'd0, core_go},    32'd0);
    chk({tag, "_load_err"},   {31'd0, load_err},   32'd0);
    chk({tag, "_byte_count"}, {24'd0, byte_count}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_sync", {31'd0, in_ready}, 32'd1);
  endtask

  // Waits for core_go while a byte is offered; nothing may be consumed.
  task automatic wait_done(input int len, input bit has_fill);
    int n;
    int go_exp;
    n = 0;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
      chk("in_ready_fill_done", {31'd0, in_ready}, 32'd0);
    end while (core_go !== 1'b1 && n < 200);
    go_exp = has_fill ? last_wr_cyc + 1 : acc_cyc;
    chk("core_go", {31'd0, core_go}, 32'd1);
    chk("core_go_cycle", cyc, go_exp);
    chk("writes_outstanding", exp_q.size(), 32'd0);
    chk("load_err_ok", {31'd0, load_err}, 32'd0);
    chk("byte_count", {24'd0, byte_count}, len);
    @(negedge clk);
    chk("core_go_held", {31'd0, core_go}, 32'd1);
    chk("wr_en_idle", {31'd0, wr_en}, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [7:0] csum, input bit gaps);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({8'(i), pl[i]});
      s = s + pl[i];
    end
    if (s == csum)
      for (int i = len; i < 64; i++) exp_q.push_back({8'(i), 8'h00});
    send(8'hA5, gaps);
    @(negedge clk);
    chk("load_err_cleared_at_sync", {31'd0, load_err}, 32'd0);
    send(8'(len), gaps);
    for (int i = 0; i < len; i++) send(pl[i], gaps);
    send(csum, gaps);
    if (s == csum) begin
      wait_done(len, len < 64);
    end else begin
      @(negedge clk);
      chk("csum_err", {31'd0, load_err}, 32'd1);
      chk("csum_no_go", {31'd0, core_go}, 32'd0);
      chk("csum_back_to_sync", {31'd0, in_ready}, 32'd1);
      chk("csum_writes_outstanding", exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();

    // Good frame with fill
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    run_frame(4, 8'h0A, 1'b0);

    // Full-length frame, no fill
    do_reset();
    for (int i = 0; i < 64; i++) pl[i] = 8'h01;
    run_frame(64, 8'h40, 1'b0);

    // Bad checksum, then a good one-byte frame
    do_reset();
    pl[0] = 8'h10; pl[1] = 8'h20;
    run_frame(2, 8'h31, 1'b0);
    pl[0] = 8'h07;
    run_frame(1, 8'h07, 1'b0);

    // Junk and bad lengths
    do_reset();
    chk("junk_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    @(negedge clk);
    chk("junk_dropped_ready", {31'd0, in_ready}, 32'd1);
    chk("junk_no_err", {31'd0, load_err}, 32'd0);
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    @(negedge clk);
    chk("len0_err", {31'd0, load_err}, 32'd1);
    send(8'hA5, 1'b0);
    @(negedge clk);
    chk("len_err_cleared", {31'd0, load_err}, 32'd0);
    send(8'h41, 1'b0);
    @(negedge clk);
    chk("len65_err", {31'd0, load_err}, 32'd1);
    chk("len_err_byte_count", {24'd0, byte_count}, 32'd0);
    chk("len_err_sync", {31'd0, in_ready}, 32'd1);

    // Good frame with random gaps
    do_reset();
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03; pl[3] = 8'h04;
    run_frame(4, 8'h0A, 1'b1);

    // Reset mid-DATA after the 2nd data byte
    do_reset();
    exp_q.push_back({8'h00, 8'h11});
    exp_q.push_back({8'h01, 8'h22});
    send(8'hA5, 1'b0);
    send(8'h08, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_writes_outstanding", exp_q.size(), 32'd0);
    pl[0] = 8'h05; pl[1] = 8'h06; pl[2] = 8'h07;
    run_frame(3, 8'h12, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
